// File: rtl/spi_sar_pkg.sv
// Shared definitions for the SPI-fronted SAR ADC controller: SAR state
// encoding and the positions of the status flags in the outgoing frame.
package spi_sar_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SAMPLE  = 2'd1,
      S_CONVERT = 2'd2,
      S_DONE    = 2'd3
   } sar_state_t;

   // Status flags ride in the two MSBs of the tx frame, above the result field
   function automatic int ovr_bit(input int frame_bits);
      return frame_bits - 1;
   endfunction

   function automatic int vld_bit(input int frame_bits);
      return frame_bits - 2;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q;

   // Reset to the line's idle level so release never fakes an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_sar_slave.sv
// SPI mode-0 slave that returns the previous SAR result and captures a config
// word, with CS fall kicking off a sample + binary-search conversion.
module spi_sar_slave
   import spi_sar_pkg::*;
#(
   parameter int N_BITS        = 10,
   parameter int FRAME_BITS    = 16,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_cs,
   input  logic                  spi_sck,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   input  logic                  cmp_in,
   output logic [N_BITS-1:0]     dac_code,
   output logic                  sample_en,
   output logic                  busy,
   output logic [N_BITS-1:0]     result,
   output logic                  result_valid,
   output logic [FRAME_BITS-1:0] cfg_word,
   output logic                  cfg_valid
);

   localparam int OVR_BIT = ovr_bit(FRAME_BITS);
   localparam int VLD_BIT = vld_bit(FRAME_BITS);
   localparam int CW      = $clog2(FRAME_BITS + 1);
   localparam int TMR_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int BW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   logic cs_sync, cs_rise, cs_fall;
   logic sck_rise, sck_fall, sck_level_unused;
   logic mosi_meta, mosi_sync;

   spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .reset(reset), .din(spi_cs),
      .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .reset(reset), .din(spi_sck),
      .sync(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mosi_meta <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         mosi_meta <= spi_mosi;
         mosi_sync <= mosi_meta;
      end
   end

   // ---------------- SPI frame side ----------------
   logic [FRAME_BITS-1:0] tx_q, rx_q, tx_init;
   logic [CW-1:0]         bitcnt_q;
   logic                  overrun_q, ever_valid_q, trig_q;

   always_comb begin
      tx_init              = '0;
      tx_init[OVR_BIT]     = overrun_q;
      tx_init[VLD_BIT]     = ever_valid_q;
      tx_init[N_BITS-1:0]  = result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_q      <= '0;
         rx_q      <= '0;
         bitcnt_q  <= '0;
         spi_miso  <= 1'b0;
         cfg_word  <= '0;
         cfg_valid <= 1'b0;
         overrun_q <= 1'b0;
         trig_q    <= 1'b0;
      end else begin
         cfg_valid <= 1'b0;
         trig_q    <= cs_fall;
         if (cs_fall) begin
            tx_q      <= tx_init;
            spi_miso  <= tx_init[OVR_BIT];
            overrun_q <= 1'b0;
            bitcnt_q  <= '0;
         end else if (cs_sync) begin
            spi_miso <= 1'b0;
            if (cs_rise && bitcnt_q == CW'(FRAME_BITS)) begin
               cfg_word  <= rx_q;
               cfg_valid <= 1'b1;
            end
         end else begin
            if (sck_rise) begin
               rx_q <= {rx_q[FRAME_BITS-2:0], mosi_sync};
               if (bitcnt_q != CW'(FRAME_BITS))
                  bitcnt_q <= bitcnt_q + CW'(1);
            end
            // Zeros shift in behind the payload, so MISO idles low after the last bit
            if (sck_fall) begin
               tx_q     <= {tx_q[FRAME_BITS-2:0], 1'b0};
               spi_miso <= tx_q[FRAME_BITS-2];
            end
         end
         // A trigger arriving while a conversion is still running is dropped but flagged
         if (trig_q && busy)
            overrun_q <= 1'b1;
      end
   end

   // ---------------- SAR conversion side ----------------
   sar_state_t        state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [BW-1:0]     bidx_q, bidx_d;
   logic [N_BITS-1:0] code_q, code_d, trial, result_d;
   logic              rv_d, ev_d;

   assign trial     = code_q | (N_BITS'(1) << bidx_q);
   assign busy      = (state_q != S_IDLE);
   assign sample_en = (state_q == S_SAMPLE);
   assign dac_code  = (state_q == S_CONVERT) ? trial : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tmr_q        <= '0;
         bidx_q       <= '0;
         code_q       <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         ever_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         bidx_q       <= bidx_d;
         code_q       <= code_d;
         result       <= result_d;
         result_valid <= rv_d;
         ever_valid_q <= ev_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bidx_d   = bidx_q;
      code_d   = code_q;
      result_d = result;
      rv_d     = 1'b0;
      ev_d     = ever_valid_q;
      case (state_q)
         S_IDLE: begin
            if (trig_q) begin
               state_d = S_SAMPLE;
               tmr_d   = '0;
            end
         end
         S_SAMPLE: begin
            if (tmr_q == TW'(SAMPLE_CYCLES - 1)) begin
               state_d = S_CONVERT;
               tmr_d   = '0;
               bidx_d  = BW'(N_BITS - 1);
               code_d  = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_CONVERT: begin
            // Comparator is only trusted on the final settle cycle of each trial
            if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
               tmr_d = '0;
               if (cmp_in)
                  code_d = trial;
               if (bidx_q == '0) begin
                  state_d  = S_DONE;
                  result_d = cmp_in ? trial : code_q;
                  rv_d     = 1'b1;
                  ev_d     = 1'b1;
               end else begin
                  bidx_d = bidx_q - BW'(1);
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_sar_slave.sv
// Randomized self-checking bench for spi_sar_slave with an ideal comparator
// and a frame-level model of result, valid and overrun status.
module tb_spi_sar_slave;

   localparam int N  = 10;
   localparam int FB = 16;

   logic          clk = 1'b0;
   logic          reset, spi_cs, spi_sck, spi_mosi, spi_miso, cmp_in;
   logic          sample_en, busy, result_valid, cfg_valid;
   logic [N-1:0]  dac_code, result, vin;
   logic [FB-1:0] cfg_word;

   int vectors = 0, miscompares = 0;
   int rv_cnt = 0, cfg_cnt = 0;

   logic          m_ovr, m_ev;
   logic [N-1:0]  m_res;
   logic [FB-1:0] m_cfg;

   always #5 clk = ~clk;
   assign cmp_in = (vin >= dac_code);

   spi_sar_slave #(.N_BITS(N), .FRAME_BITS(FB), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .cmp_in(cmp_in), .dac_code(dac_code), .sample_en(sample_en),
      .busy(busy), .result(result), .result_valid(result_valid),
      .cfg_word(cfg_word), .cfg_valid(cfg_valid)
   );

   always @(negedge clk) begin
      if (result_valid) rv_cnt++;
      if (cfg_valid) cfg_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [FB-1:0] exp_frame();
      return {m_ovr, m_ev, {(FB-N-2){1'b0}}, m_res};
   endfunction

   task automatic do_reset();
      reset = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      m_ovr = 1'b0; m_ev = 1'b0; m_res = '0; m_cfg = '0;
   endtask

   // Mode 0: master drives MOSI and samples MISO while SCK is low, each level held 6 clk
   task automatic spi_frame(input logic [FB-1:0] w, input int nsck, output logic [FB-1:0] m);
      m = '0;
      spi_cs = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nsck; i++) begin
         spi_mosi = w[FB-1-i];
         repeat (6) @(negedge clk);
         m[FB-1-i] = spi_miso;
         spi_sck = 1'b1;
         repeat (6) @(negedge clk);
         spi_sck = 1'b0;
      end
      repeat (6) @(negedge clk);
      spi_cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({spi_miso, sample_en, busy, result_valid, cfg_valid} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset.flags got %b want 00000", {spi_miso, sample_en, busy, result_valid, cfg_valid});
      end
      vectors++;
      if (dac_code !== '0 || result !== '0) begin
         miscompares++;
         $display("FAIL reset.codes got dac=%h result=%h want 0/0", dac_code, result);
      end
      vectors++;
      if (cfg_word !== '0) begin
         miscompares++;
         $display("FAIL reset.cfg_word got %h want 0000", cfg_word);
      end
   endtask

   // CS pulse with no SCK: checks conversion timing and the DAC trial sequence
   task automatic test_conv(input logic [N-1:0] v);
      logic [N-1:0] exp_q[$], got_q[$];
      logic [N-1:0] code, t, last, got_res;
      int samp, t_samp, t_rv, rv_n, c0;
      bit busy_seen;
      samp = 0; t_samp = -1; t_rv = -1; rv_n = 0; busy_seen = 0;
      last = '0; got_res = '0; code = '0;
      for (int i = N-1; i >= 0; i--) begin
         t = code + N'(1 << i);
         exp_q.push_back(t);
         if (v >= t) code = t;
      end
      vin = v;
      c0 = cfg_cnt;
      spi_cs = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (busy) busy_seen = 1;
         if (sample_en) begin
            samp++;
            if (t_samp < 0) t_samp = c;
         end
         if (dac_code != '0 && dac_code != last) got_q.push_back(dac_code);
         last = dac_code;
         if (result_valid) begin
            rv_n++;
            t_rv = c;
            got_res = result;
         end
      end
      spi_cs = 1'b1;
      repeat (8) @(negedge clk);
      vectors++;
      if (!busy_seen || samp != 4) begin
         miscompares++;
         $display("FAIL conv.sample v=%h got busy=%0d sample_cycles=%0d want 1/4", v, busy_seen, samp);
      end
      vectors++;
      if (rv_n != 1 || t_rv - t_samp != 24) begin
         miscompares++;
         $display("FAIL conv.latency v=%h got pulses=%0d latency=%0d want 1/24", v, rv_n, t_rv - t_samp);
      end
      vectors++;
      if (got_res !== v) begin
         miscompares++;
         $display("FAIL conv.result got %h want %h", got_res, v);
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL conv.trial_count v=%h got %0d want %0d", v, got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL conv.trial[%0d] v=%h got %h want %h", i, v, got_q[i], exp_q[i]);
            end
         end
      end
      vectors++;
      if (cfg_cnt != c0 || cfg_word !== m_cfg) begin
         miscompares++;
         $display("FAIL conv.no_cfg got pulses=%0d cfg=%h want 0/%h", cfg_cnt - c0, cfg_word, m_cfg);
      end
      m_res = v; m_ev = 1'b1;
   endtask

   task automatic test_frame(input logic [FB-1:0] w, input logic [N-1:0] v);
      logic [FB-1:0] exp, got;
      int c0, r0;
      exp = exp_frame();
      vin = v; c0 = cfg_cnt; r0 = rv_cnt;
      spi_frame(w, 16, got);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL frame.miso got %h want %h", got, exp);
      end
      vectors++;
      if (cfg_cnt - c0 != 1 || cfg_word !== w) begin
         miscompares++;
         $display("FAIL frame.cfg got pulses=%0d cfg=%h want 1/%h", cfg_cnt - c0, cfg_word, w);
      end
      vectors++;
      if (rv_cnt - r0 != 1 || result !== v) begin
         miscompares++;
         $display("FAIL frame.conv got pulses=%0d result=%h want 1/%h", rv_cnt - r0, result, v);
      end
      m_ovr = 1'b0; m_cfg = w; m_res = v; m_ev = 1'b1;
   endtask

   // Second CS fall lands mid-conversion: must not disturb it, must flag overrun
   task automatic test_overrun(input logic [N-1:0] v);
      int c0, r0;
      vin = v; c0 = cfg_cnt; r0 = rv_cnt;
      spi_cs = 1'b0; repeat (8) @(negedge clk);
      spi_cs = 1'b1; repeat (6) @(negedge clk);
      spi_cs = 1'b0; repeat (6) @(negedge clk);
      spi_cs = 1'b1; repeat (40) @(negedge clk);
      vectors++;
      if (rv_cnt - r0 != 1 || result !== v || cfg_cnt != c0) begin
         miscompares++;
         $display("FAIL overrun.conv got pulses=%0d result=%h cfg_pulses=%0d want 1/%h/0",
                  rv_cnt - r0, result, cfg_cnt - c0, v);
      end
      m_res = v; m_ev = 1'b1; m_ovr = 1'b1;
      test_frame(16'($urandom), 10'($urandom));
      test_frame(16'($urandom), 10'($urandom));
   endtask

   task automatic test_abort(input logic [FB-1:0] w, input logic [N-1:0] v);
      logic [FB-1:0] exp, got;
      int c0;
      exp = exp_frame();
      vin = v; c0 = cfg_cnt;
      spi_frame(w, 7, got);
      vectors++;
      if (got[FB-1 -: 7] !== exp[FB-1 -: 7]) begin
         miscompares++;
         $display("FAIL abort.miso got %h want %h", got[FB-1 -: 7], exp[FB-1 -: 7]);
      end
      vectors++;
      if (cfg_cnt != c0 || cfg_word !== m_cfg) begin
         miscompares++;
         $display("FAIL abort.cfg got pulses=%0d cfg=%h want 0/%h", cfg_cnt - c0, cfg_word, m_cfg);
      end
      vectors++;
      if (spi_miso !== 1'b0) begin
         miscompares++;
         $display("FAIL abort.miso_idle got %b want 0", spi_miso);
      end
      m_res = v; m_ev = 1'b1; m_ovr = 1'b0;
   endtask

   task automatic test_reset_mid(input logic [N-1:0] v);
      vin = v;
      spi_cs = 1'b0;
      repeat (14) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || dac_code === '0) begin
         miscompares++;
         $display("FAIL rstmid.converting got busy=%b dac=%h want 1/nonzero", busy, dac_code);
      end
      reset = 1'b1; spi_cs = 1'b1;
      @(negedge clk);
      vectors++;
      if ({spi_miso, sample_en, busy, result_valid, cfg_valid} !== 5'b0 ||
          dac_code !== '0 || result !== '0 || cfg_word !== '0) begin
         miscompares++;
         $display("FAIL rstmid.outputs got flags=%b dac=%h result=%h cfg=%h want 0",
                  {spi_miso, sample_en, busy, result_valid, cfg_valid}, dac_code, result, cfg_word);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      m_ovr = 1'b0; m_ev = 1'b0; m_res = '0; m_cfg = '0;
      test_conv(10'($urandom));
      test_frame(16'($urandom), 10'($urandom));
   endtask

   initial begin
      vin = '0;
      test_reset();
      test_conv(10'h2A5);
      test_conv(10'h000);
      test_conv(10'h3FF);
      for (int i = 0; i < 3; i++) test_conv(10'($urandom));
      test_conv(10'h2A5);
      test_frame(16'hA5C3, 10'($urandom));
      test_frame(16'($urandom), 10'($urandom));
      test_overrun(10'($urandom));
      test_abort(16'($urandom), 10'($urandom));
      test_reset_mid(10'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
